// File: rtl/mux4x1_pkg.sv
// Shared constants and types for the 4-channel round-robin mux/demux path.
package mux4x1_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef logic [SEL_W-1:0] sel_t;

  // Last-grant pointer reset value; makes the first search order 0,1,2,3.
  localparam sel_t PTR_RST = 2'b11;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: searches ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_arb4
  import mux4x1_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic              gnt_vld,
  output sel_t              gnt_idx
);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      if (!gnt_vld && req[sel_t'(ptr + sel_t'(k))]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel_t'(ptr + sel_t'(k));
      end
    end
  end

endmodule

// File: rtl/mux4x1_rr.sv
// Four-input round-robin merging mux with a registered, source-tagged output beat.
// Optional per-channel grant counters are enabled by defining MUX4X1_RR_CNT_EN.
module mux4x1_rr
  import mux4x1_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_CH*DW-1:0] in_data,
  input  logic [NUM_CH-1:0]    in_valid,
  output logic [NUM_CH-1:0]    in_ready,
  output logic [DW-1:0]        out_data,
  output sel_t                 out_sel,
  output logic                 out_valid,
`ifdef MUX4X1_RR_CNT_EN
  input  logic                 cnt_clr,
  output logic [31:0]          grant_cnt,
`endif
  input  logic                 out_ready
);

  logic [DW-1:0] r_out_data;
  sel_t          r_out_sel;
  logic          r_out_valid;
  sel_t          r_ptr;

  logic w_load;
  logic w_gnt_vld;
  sel_t w_gnt_idx;
  logic w_take;

  rr_arb4 u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_vld (w_gnt_vld),
    .gnt_idx (w_gnt_idx)
  );

  assign w_load   = enable && (!r_out_valid || out_ready);
  assign w_take   = w_load && w_gnt_vld;
  assign in_ready = w_take ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= PTR_RST;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_out_data  <= in_data[w_gnt_idx*DW +: DW];
        r_out_sel   <= w_gnt_idx;
        r_out_valid <= 1'b1;
        r_ptr       <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (r_out_valid && out_ready) begin
      // Disabled: the held beat still drains, but nothing replaces it.
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

`ifdef MUX4X1_RR_CNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_clr) begin
          r_cnt[i] <= '0;
        end else if (w_take && (w_gnt_idx == sel_t'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_mux4x1_rr.sv
// Self-checking bench for mux4x1_rr; counter checks run when MUX4X1_RR_CNT_EN is defined.
module tb_mux4x1_rr;
  import mux4x1_pkg::*;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [DW-1:0]   out_data;
  sel_t            out_sel;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX4X1_RR_CNT_EN
  logic            cnt_clr;
  logic [31:0]     grant_cnt;
`endif

  mux4x1_rr #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
`ifdef MUX4X1_RR_CNT_EN
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: last-granted channel, the held beat, and per-channel grant counts.
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_sel;
  int         m_cnt [4];

  function automatic int winner();
    for (int k = 1; k <= 4; k++) begin
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit m_load();
    return enable && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr   <= 3;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
    end else begin
`ifdef MUX4X1_RR_CNT_EN
      if (cnt_clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
      end else if (m_load() && winner() >= 0 && m_cnt[winner()] < 255) begin
        m_cnt[winner()] <= m_cnt[winner()] + 1;
      end
`endif
      if (m_load()) begin
        if (winner() >= 0) begin
          m_data  <= in_data[winner()*8 +: 8];
          m_sel   <= winner();
          m_valid <= 1'b1;
          m_ptr   <= winner();
        end else begin
          m_valid <= 1'b0;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0] exp_rdy;
      exp_rdy = (m_load() && winner() >= 0) ? (4'b0001 << winner()) : 4'b0000;
      chk("model_in_ready", in_ready, exp_rdy);
      chk("model_out_valid", out_valid, m_valid);
      chk("model_out_data", out_data, m_data);
      chk("model_out_sel", out_sel, m_sel);
`ifdef MUX4X1_RR_CNT_EN
      for (int i = 0; i < 4; i++) chk("model_grant_cnt", grant_cnt[i*8 +: 8], m_cnt[i]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] held_data;
    logic [1:0] exp_seq [8];
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef MUX4X1_RR_CNT_EN
    cnt_clr   = 1'b0;
`endif
    repeat (2) tick();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_out_sel", out_sel, 2'b00);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Single beat on ch0.
    in_valid = 4'b0001;
    in_data[7:0] = 8'hA5;
    #1;
    chk("ch0_in_ready", in_ready, 4'b0001);
    tick();
    in_valid = '0;
    chk("ch0_out_valid", out_valid, 1'b1);
    chk("ch0_out_data", out_data, 8'hA5);
    chk("ch0_out_sel", out_sel, 2'b00);

    // All four valid from a fresh pointer: strict rotation, no bubbles.
    pulse_reset();
    in_data  = 32'h44332211;
    in_valid = 4'b1111;
    exp_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rot_out_sel", out_sel, exp_seq[i]);
      chk("rot_out_valid", out_valid, 1'b1);
    end

    // Backpressure holds the ch3 beat, then drain and ch2 load in one cycle.
    out_ready = 1'b0;
    held_data = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_sel", out_sel, 2'd3);
      chk("bp_out_data", out_data, held_data);
      chk("bp_in_ready", in_ready, 4'b0000);
    end
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 4'b0100);
    tick();
    chk("bp_release_sel", out_sel, 2'd2);
    chk("bp_release_data", out_data, 8'h33);

    // Disable while a beat is held.
    out_ready = 1'b0;
    enable    = 1'b0;
    in_valid  = 4'b1111;
    tick();
    chk("dis_held_valid", out_valid, 1'b1);
    chk("dis_in_ready", in_ready, 4'b0000);
    out_ready = 1'b1;
    tick();
    chk("dis_drained_valid", out_valid, 1'b0);
    chk("dis_drained_in_ready", in_ready, 4'b0000);
    enable = 1'b1;
    #1;
    chk("reen_in_ready", in_ready, 4'b1000);
    tick();
    chk("reen_out_sel", out_sel, 2'd3);

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b1010;
    tick();
    chk("post_rst_sel", out_sel, 2'd1);
    chk("post_rst_valid", out_valid, 1'b1);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      tick();
    end

`ifdef MUX4X1_RR_CNT_EN
    enable    = 1'b1;
    out_ready = 1'b1;
    pulse_reset();
    in_valid  = 4'b1000;
    repeat (300) tick();
    chk("cnt_saturated", grant_cnt, 32'hFF00_0000);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_cleared", grant_cnt, 32'h0000_0000);
`endif

    in_valid = '0;
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
